// File: rtl/control.sv
// Multicycle Moore control unit for the LC-3b datapath, with a retired-instruction counter.
// Optional shift support is enabled by defining CONTROL_SHF_EN; otherwise op_shf retires as a NOP.

package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add,
        alu_and,
        alu_not,
        alu_pass,
        alu_sll,
        alu_srl,
        alu_sra
    } lc3b_aluop;

endpackage

module control
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  lc3b_opcode           opcode,
    input  logic                 instruction5,
    input  logic                 instruction4,
    input  logic                 branch_enable,
    input  logic                 mem_resp,
    output logic [1:0]           pcmux_sel,
    output logic                 storemux_sel,
    output logic [1:0]           alumux_sel,
    output logic                 marmux_sel,
    output logic                 mdrmux_sel,
    output logic [1:0]           regfilemux_sel,
    output logic                 load_pc,
    output logic                 load_cc,
    output logic                 load_ir,
    output logic                 load_mar,
    output logic                 load_mdr,
    output logic                 load_regfile,
    output lc3b_aluop            aluop,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [4:0] {
        s_fetch1,
        s_fetch2,
        s_fetch3,
        s_decode,
        s_add,
        s_and,
        s_not,
`ifdef CONTROL_SHF_EN
        s_shf,
`endif
        s_br_taken,
        s_jmp,
        s_lea,
        s_ldr1,
        s_ldr2,
        s_ldr3,
        s_str1,
        s_str2,
        s_str3
    } state_t;

    state_t state;
    state_t next_state;
    logic   retire;

`ifndef CONTROL_SHF_EN
    logic unused_shf_bits;
    assign unused_shf_bits = instruction4;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= s_fetch1;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (retire)
                instr_count <= instr_count + CNT_WIDTH'(1);
        end
    end

    // An instruction retires on the cycle that hands control back to FETCH1.
    always_comb begin
        retire = 1'b0;
        if (next_state == s_fetch1 &&
            state != s_fetch1 && state != s_fetch2 && state != s_fetch3)
            retire = 1'b1;
    end

    always_comb begin
        next_state     = state;
        pcmux_sel      = 2'd0;
        storemux_sel   = 1'b0;
        alumux_sel     = 2'd0;
        marmux_sel     = 1'b0;
        mdrmux_sel     = 1'b0;
        regfilemux_sel = 2'd0;
        load_pc        = 1'b0;
        load_cc        = 1'b0;
        load_ir        = 1'b0;
        load_mar       = 1'b0;
        load_mdr       = 1'b0;
        load_regfile   = 1'b0;
        aluop          = alu_add;
        mem_read       = 1'b0;
        mem_write      = 1'b0;

        case (state)
            s_fetch1: begin
                marmux_sel = 1'b1;
                load_mar   = 1'b1;
                next_state = s_fetch2;
            end
            s_fetch2: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = mem_resp;
                if (mem_resp)
                    next_state = s_fetch3;
            end
            s_fetch3: begin
                load_ir    = 1'b1;
                pcmux_sel  = 2'd0;
                load_pc    = 1'b1;
                next_state = s_decode;
            end
            // Branch condition is resolved here so a not-taken branch retires in 4 cycles.
            s_decode: begin
                case (opcode)
                    op_add: next_state = s_add;
                    op_and: next_state = s_and;
                    op_not: next_state = s_not;
`ifdef CONTROL_SHF_EN
                    op_shf: next_state = s_shf;
`endif
                    op_br:  next_state = branch_enable ? s_br_taken : s_fetch1;
                    op_jmp: next_state = s_jmp;
                    op_lea: next_state = s_lea;
                    op_ldr: next_state = s_ldr1;
                    op_str: next_state = s_str1;
                    default: next_state = s_fetch1;
                endcase
            end
            s_add, s_and: begin
                aluop        = (state == s_add) ? alu_add : alu_and;
                alumux_sel   = instruction5 ? 2'd1 : 2'd0;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                next_state   = s_fetch1;
            end
            s_not: begin
                aluop        = alu_not;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                next_state   = s_fetch1;
            end
`ifdef CONTROL_SHF_EN
            s_shf: begin
                alumux_sel = 2'd3;
                if (!instruction4)
                    aluop = alu_sll;
                else
                    aluop = instruction5 ? alu_sra : alu_srl;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                next_state   = s_fetch1;
            end
`endif
            s_br_taken: begin
                pcmux_sel  = 2'd1;
                load_pc    = 1'b1;
                next_state = s_fetch1;
            end
            s_jmp: begin
                pcmux_sel  = 2'd2;
                load_pc    = 1'b1;
                next_state = s_fetch1;
            end
            s_lea: begin
                regfilemux_sel = 2'd2;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
                next_state     = s_fetch1;
            end
            s_ldr1, s_str1: begin
                alumux_sel = 2'd2;
                aluop      = alu_add;
                marmux_sel = 1'b0;
                load_mar   = 1'b1;
                next_state = (state == s_ldr1) ? s_ldr2 : s_str2;
            end
            s_ldr2: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = mem_resp;
                if (mem_resp)
                    next_state = s_ldr3;
            end
            s_ldr3: begin
                regfilemux_sel = 2'd1;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
                next_state     = s_fetch1;
            end
            s_str2: begin
                storemux_sel = 1'b1;
                aluop        = alu_pass;
                mdrmux_sel   = 1'b0;
                load_mdr     = 1'b1;
                next_state   = s_str3;
            end
            s_str3: begin
                mem_write = 1'b1;
                if (mem_resp)
                    next_state = s_fetch1;
            end
            default: next_state = s_fetch1;
        endcase
    end

endmodule

// File: tb/tb_control.sv
// Randomized scoreboard bench for the LC-3b control unit; honours CONTROL_SHF_EN like the design.
module tb_control;
    import lc3b_types::*;

    localparam int N_INSTR = 150;

    logic              clock = 1'b0;
    logic              reset;
    lc3b_opcode        opcode;
    logic              instruction5, instruction4, branch_enable, mem_resp;
    logic [1:0]        pcmux_sel, alumux_sel, regfilemux_sel;
    logic              storemux_sel, marmux_sel, mdrmux_sel;
    logic              load_pc, load_cc, load_ir, load_mar, load_mdr, load_regfile;
    lc3b_aluop         aluop;
    logic              mem_read, mem_write;
    logic [15:0]       instr_count;

    control #(.CNT_WIDTH(16)) dut (
        .clk(clock), .reset(reset), .opcode(opcode),
        .instruction5(instruction5), .instruction4(instruction4),
        .branch_enable(branch_enable), .mem_resp(mem_resp),
        .pcmux_sel(pcmux_sel), .storemux_sel(storemux_sel), .alumux_sel(alumux_sel),
        .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel), .regfilemux_sel(regfilemux_sel),
        .load_pc(load_pc), .load_cc(load_cc), .load_ir(load_ir), .load_mar(load_mar),
        .load_mdr(load_mdr), .load_regfile(load_regfile), .aluop(aluop),
        .mem_read(mem_read), .mem_write(mem_write), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int op; bit i5; bit i4; bit be; int fwait; int mwait;
    } instr_t;

    typedef struct {
        int cycles; bit wr_reg; int alumux; int aluop; int rfmux;
        bit redirect; int pcsel; int rd_cyc; int wr_cyc; int mdr_cyc; bit is_str;
    } exp_t;

    exp_t   sb[$];
    instr_t cur;
    int     checks = 0;
    int     failures = 0;
    int     issued = 0;
    int     done = 0;
    bit     final_issued = 0;
    bit     monitor_on = 0;
    bit     stim_on = 0;
    bit     in_fetch = 1;
    int     acc_cnt = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference behaviour: what one instruction should look like from fetch to retire.
    function automatic exp_t model(input instr_t t);
        exp_t e;
        e = '{cycles: 4 + t.fwait, wr_reg: 0, alumux: 0, aluop: int'(alu_add), rfmux: 0,
              redirect: 0, pcsel: 0, rd_cyc: 1 + t.fwait, wr_cyc: 0, mdr_cyc: 1, is_str: 0};
        case (t.op)
            1, 5, 9: begin
                e.cycles = 5 + t.fwait;
                e.wr_reg = 1;
                e.alumux = (t.op == 9) ? 0 : (t.i5 ? 1 : 0);
                e.aluop  = (t.op == 1) ? int'(alu_add) : (t.op == 5) ? int'(alu_and) : int'(alu_not);
            end
`ifdef CONTROL_SHF_EN
            13: begin
                e.cycles = 5 + t.fwait;
                e.wr_reg = 1;
                e.alumux = 3;
                e.aluop  = !t.i4 ? int'(alu_sll) : (t.i5 ? int'(alu_sra) : int'(alu_srl));
            end
`endif
            0: if (t.be) begin
                e.cycles = 5 + t.fwait; e.redirect = 1; e.pcsel = 1;
            end
            12: begin
                e.cycles = 5 + t.fwait; e.redirect = 1; e.pcsel = 2;
            end
            14: begin
                e.cycles = 5 + t.fwait; e.wr_reg = 1; e.rfmux = 2;
            end
            6: begin
                e.cycles = 7 + t.fwait + t.mwait; e.wr_reg = 1; e.rfmux = 1;
                e.rd_cyc += 1 + t.mwait; e.mdr_cyc = 2;
            end
            7: begin
                e.cycles = 7 + t.fwait + t.mwait; e.wr_cyc = 1 + t.mwait;
                e.mdr_cyc = 2; e.is_str = 1;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Memory responder: answers each access after the chosen number of wait cycles,
    // and toggles mem_resp randomly while no access is pending.
    always @(negedge clock) begin
        if (mem_read || mem_write) begin
            mem_resp = (acc_cnt == (in_fetch ? cur.fwait : cur.mwait));
            acc_cnt++;
        end else begin
            mem_resp = 1'($urandom_range(0, 1));
            acc_cnt  = 0;
        end
    end

    // Stimulus: a new instruction is chosen each time the DUT starts a fetch.
    always @(negedge clock) begin
        if (stim_on && marmux_sel && load_mar) begin
            if (issued < N_INSTR) begin
                cur.op = $urandom_range(0, 15);
                cur.i5 = 1'($urandom_range(0, 1));
                cur.i4 = 1'($urandom_range(0, 1));
                cur.be = 1'($urandom_range(0, 1));
                cur.fwait = $urandom_range(0, 3);
                cur.mwait = $urandom_range(0, 3);
                sb.push_back(model(cur));
                issued++;
            end else if (!final_issued) begin
                cur = '{op: 6, i5: 0, i4: 0, be: 0, fwait: 0, mwait: 40};
                final_issued = 1;
            end
            opcode        = lc3b_opcode'(cur.op[3:0]);
            instruction5  = cur.i5;
            instruction4  = cur.i4;
            branch_enable = cur.be;
            in_fetch      = 1;
        end else if (load_ir) begin
            in_fetch = 0;
        end
    end

    int cyc, rd_cyc, wr_cyc, mdr_cyc, start_cnt;
    int cap_alumux, cap_aluop, cap_rfmux, cap_pcsel, cap_storemux, cap_st_aluop;
    bit open_w = 0, seen_wr, redirect, cc_bad;

    task automatic closeWindow();
        exp_t e;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL scoreboard_underflow actual=empty expected=entry at %0t", $time);
            return;
        end
        e = sb.pop_front();
        checkOutput("latency", cyc, e.cycles);
        checkOutput("load_regfile_seen", int'(seen_wr), int'(e.wr_reg));
        if (e.wr_reg) begin
            checkOutput("alumux_sel", cap_alumux, e.alumux);
            checkOutput("aluop", cap_aluop, e.aluop);
            checkOutput("regfilemux_sel", cap_rfmux, e.rfmux);
        end
        checkOutput("pc_redirect", int'(redirect), int'(e.redirect));
        if (e.redirect)
            checkOutput("pcmux_sel", cap_pcsel, e.pcsel);
        checkOutput("mem_read_cycles", rd_cyc, e.rd_cyc);
        checkOutput("mem_write_cycles", wr_cyc, e.wr_cyc);
        checkOutput("load_mdr_cycles", mdr_cyc, e.mdr_cyc);
        checkOutput("load_cc_with_regfile", int'(cc_bad), 0);
        if (e.is_str) begin
            checkOutput("str2_storemux", cap_storemux, 1);
            checkOutput("str2_aluop", cap_st_aluop, int'(alu_pass));
        end
        checkOutput("instr_count", int'(instr_count), (start_cnt + 1) % 65536);
        done++;
    endtask

    // Monitor: each FETCH1 closes the previous instruction's window and opens a new one.
    always begin
        @(negedge clock);
        #1;
        if (!monitor_on) begin
            open_w = 0;
        end else begin
            if (marmux_sel && load_mar) begin
                if (open_w)
                    closeWindow();
                open_w = 1; cyc = 0; rd_cyc = 0; wr_cyc = 0; mdr_cyc = 0;
                seen_wr = 0; redirect = 0; cc_bad = 0;
                cap_alumux = 0; cap_aluop = 0; cap_rfmux = 0; cap_pcsel = 0;
                cap_storemux = 0; cap_st_aluop = 0;
                start_cnt = int'(instr_count);
            end
            if (open_w) begin
                cyc++;
                if (mem_read)  rd_cyc++;
                if (mem_write) wr_cyc++;
                if (load_mdr)  mdr_cyc++;
                if (load_cc != load_regfile) cc_bad = 1;
                if (load_regfile) begin
                    seen_wr = 1; cap_alumux = int'(alumux_sel);
                    cap_aluop = int'(aluop); cap_rfmux = int'(regfilemux_sel);
                end
                if (load_pc && pcmux_sel != 2'd0) begin
                    redirect = 1; cap_pcsel = int'(pcmux_sel);
                end
                if (load_mdr && !mdrmux_sel) begin
                    cap_storemux = int'(storemux_sel); cap_st_aluop = int'(aluop);
                end
            end
        end
    end

    task automatic applyStimulus(input int reset_cycles);
        reset = 1'b1;
        repeat (reset_cycles) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        bit hit;
        reset = 1'b1; opcode = op_br; instruction5 = 0; instruction4 = 0; branch_enable = 0;
        cur = '{op: 0, i5: 0, i4: 0, be: 0, fwait: 0, mwait: 0};
        $display("[TB] reset phase");
        applyStimulus(3);
        #1;
        checkOutput("reset_marmux_sel", int'(marmux_sel), 1);
        checkOutput("reset_load_mar", int'(load_mar), 1);
        checkOutput("reset_mem_read", int'(mem_read), 0);
        checkOutput("reset_load_pc", int'(load_pc), 0);
        checkOutput("reset_instr_count", int'(instr_count), 0);
        @(negedge clock); #1;
        checkOutput("fetch2_mem_read", int'(mem_read), 1);
        @(negedge clock); #3;
        reset = 1'b1; monitor_on = 1; stim_on = 1;
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] random instruction stream of %0d", N_INSTR);
        for (int k = 0; k < 30000 && done < N_INSTR; k++)
            @(negedge clock);
        checkOutput("instructions_retired", done, N_INSTR);
        checkOutput("scoreboard_drained", sb.size(), 0);

        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clock); #1;
            if (final_issued && !in_fetch && mem_read) hit = 1;
        end
        checkOutput("reached_ldr2", int'(hit), 1);
        monitor_on = 0; stim_on = 0;
        reset = 1'b1;
        @(negedge clock); #1;
        checkOutput("abort_mem_read", int'(mem_read), 0);
        checkOutput("abort_mem_write", int'(mem_write), 0);
        checkOutput("abort_fetch1_load_mar", int'(load_mar && marmux_sel), 1);
        checkOutput("abort_instr_count", int'(instr_count), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
